spi_slave_responder: RTL and testbench

Clock-oversampled SPI slave that sits on the far side of the SPI bus from the master under test. It replaces the plain MOSI-to-MISO echo on the FPGA tester. It captures each MOSI frame into rx_data and drives MISO from a word latched at frame start, so the master's received data can be checked against known values. It supports all four CPOL/CPHA modes and the 8/16/24/32-bit transaction lengths.

---
 rtl/spi_slave_responder.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: clock-oversampled SPI slave used as the far-end responder for a master
// under test. Each MOSI frame is captured into rx_data; MISO replays a word latched at frame start.
// All four CPOL/CPHA modes and 8/16/24/32-bit frames are supported.
//
// Optional feature: define SPI_SLAVE_ECHO_EN to reply with the previous rx_data instead of
// tx_data (first frame after reset returns 0; tx_data is then unused).
//
// Ports:
//   clk, rst             system clock, asynchronous active-low reset
//   SCLK, CS, MOSI       SPI bus from the master (asynchronous, synchronized internally)
//   MISO                 registered serial reply to the master
//   CPOL, CPHA           SPI mode, sampled at frame start
//   transaction_length   frame length 0..3 -> 8/16/24/32 bits, sampled at frame start
//   tx_data              reply word, low N bits latched at frame start
//   rx_data, rx_valid    last good frame (right-aligned) and its one-cycle update strobe
//   busy                 frame in progress
//   frame_error          sticky: a frame ended with a bit count other than N
module spi_slave_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic [1:0]  transaction_length,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        frame_error
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   cpol_q, cpha_q, pend_q;
  logic [5:0]             n_q, cnt_q;
  logic [31:0]            tx_sr_q, rx_sr_q;

  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic        lead_edge, trail_edge, sample_evt, shift_evt;
  logic [5:0]  n_sel;
  logic [31:0] load_word, load_aligned;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign cs_fall   = cs_prev_q & ~cs_s;

  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
  assign sample_evt = cpha_q ? trail_edge : lead_edge;
  assign shift_evt  = cpha_q ? lead_edge : trail_edge;

  assign n_sel = {1'b0, transaction_length, 3'b000} + 6'd8;

`ifdef SPI_SLAVE_ECHO_EN
  logic unused_tx_data;
  assign unused_tx_data = ^tx_data;
  assign load_word = rx_data;
`else
  assign load_word = tx_data;
`endif

  // Left-justify the low N bits so the frame MSB sits at bit 31.
  assign load_aligned = load_word << (6'd32 - n_sel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      // CS chain resets low so a frame already in flight at reset release is not seen as a start.
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      pend_q      <= 1'b0;
      n_q         <= 6'd0;
      cnt_q       <= 6'd0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      MISO        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      rx_valid    <= 1'b0;

      case (state_q)
        StIdle: begin
          if (cs_fall || pend_q) begin
            pend_q  <= 1'b0;
            cpol_q  <= CPOL;
            cpha_q  <= CPHA;
            n_q     <= n_sel;
            cnt_q   <= 6'd0;
            rx_sr_q <= '0;
            busy    <= 1'b1;
            if (!CPHA) begin
              // Mode with CPHA=0: first bit must be on MISO before the first leading edge.
              MISO    <= load_aligned[31];
              tx_sr_q <= {load_aligned[30:0], 1'b0};
            end else begin
              tx_sr_q <= load_aligned;
            end
            state_q <= StActive;
          end
        end

        StActive: begin
          if (cs_rise) begin
            state_q <= StDone;
          end else begin
            if (sample_evt) begin
              if (cnt_q < n_q) begin
                rx_sr_q <= {rx_sr_q[30:0], mosi_s};
                cnt_q   <= cnt_q + 6'd1;
              end else if (cnt_q == n_q) begin
                // Saturate one past N so an over-long frame is flagged.
                cnt_q <= n_q + 6'd1;
              end
            end
            if (shift_evt && (cnt_q < n_q)) begin
              MISO    <= tx_sr_q[31];
              tx_sr_q <= {tx_sr_q[30:0], 1'b0};
            end
          end
        end

        StDone: begin
          if (cnt_q == n_q) begin
            rx_data  <= rx_sr_q;
            rx_valid <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
          // A new frame that starts during this cycle is started from IDLE next cycle.
          if (cs_fall) begin
            pend_q <= 1'b1;
          end
          busy    <= 1'b0;
          MISO    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: a timed SPI master drives directed frames, a
// reference model tracks rx_data/rx_valid/busy/frame_error from frame boundaries and the
// documented latencies, and a per-cycle compare process checks the DUT against it.
module tb_spi_slave_responder;

  localparam int SYNC = 2;
  localparam int H    = 8;  // SCLK half period in clk cycles

  logic        clk, rst, SCLK, CS, MOSI, MISO, CPOL, CPHA;
  logic [1:0]  transaction_length;
  logic [31:0] tx_data, rx_data;
  logic        rx_valid, busy, frame_error;

  spi_slave_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk                (clk),
    .rst                (rst),
    .SCLK               (SCLK),
    .CS                 (CS),
    .MOSI               (MOSI),
    .MISO               (MISO),
    .CPOL               (CPOL),
    .CPHA               (CPHA),
    .transaction_length (transaction_length),
    .tx_data            (tx_data),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .busy               (busy),
    .frame_error        (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic        m_busy = 1'b0, m_valid = 1'b0, m_ferr = 1'b0, pend_good = 1'b0;
  logic [31:0] m_rx = '0, pend_word = '0;
  int          busy_on_in = 0, busy_off_in = 0, commit_in = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int n);
    logic [31:0] one;
    one = 32'h1;
    return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'h1);
  endfunction

  // Model advances on clk: busy rises SYNC+1 clk after CS falls; busy falls and the frame
  // result appears SYNC+2 clk after CS rises.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      if (busy_on_in > 0) begin
        busy_on_in--;
        if (busy_on_in == 0) m_busy = 1'b1;
      end
      if (busy_off_in > 0) begin
        busy_off_in--;
        if (busy_off_in == 0) m_busy = 1'b0;
      end
      if (commit_in > 0) begin
        commit_in--;
        if (commit_in == 0) begin
          if (pend_good) begin
            m_rx    = pend_word;
            m_valid = 1'b1;
          end else begin
            m_ferr = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_valid", {31'b0, rx_valid}, {31'b0, m_valid});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("rx_data", rx_data, m_rx);
      check("frame_error", {31'b0, frame_error}, {31'b0, m_ferr});
      if (!m_busy) check("miso_idle", {31'b0, MISO}, 32'h0);
      if (rx_valid === 1'b1) pulses++;
    end
  end

  task automatic spi_frame(input logic cpol, input logic cpha, input logic [1:0] tl,
                           input logic [31:0] tx, input logic [31:0] mosi, input int ncyc,
                           input bit release_cs, input bit model_on, output logic [31:0] got);
    int          n;
    logic [31:0] msk, exp_reply;
    logic        b;
    n   = (int'(tl) + 1) * 8;
    msk = mask_of(n);
    got = '0;
    @(negedge clk);
    CPOL = cpol;
    CPHA = cpha;
    transaction_length = tl;
    tx_data = tx;
    SCLK = cpol;
`ifdef SPI_SLAVE_ECHO_EN
    exp_reply = m_rx & msk;
`else
    exp_reply = tx & msk;
`endif
    repeat (4) @(negedge clk);
    CS = 1'b0;
    if (model_on) busy_on_in = SYNC + 1;
    repeat (H) @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      b = (k < n) ? mosi[n-1-k] : 1'b0;
      if (k == 1) begin
        // Config and reply word are frame-start samples only.
        tx_data = ~tx;
        transaction_length = ~tl;
        CPHA = ~cpha;
        CPOL = ~cpol;
      end
      if (!cpha) begin
        MOSI = b;
        repeat (H) @(negedge clk);
        SCLK = ~cpol;
        got  = {got[30:0], MISO};
        repeat (H) @(negedge clk);
        SCLK = cpol;
      end else begin
        SCLK = ~cpol;
        MOSI = b;
        repeat (H) @(negedge clk);
        SCLK = cpol;
        got  = {got[30:0], MISO};
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
    if (release_cs) begin
      CS = 1'b1;
      if (model_on) begin
        busy_off_in = SYNC + 2;
        commit_in   = SYNC + 2;
        pend_good   = (ncyc == n);
        pend_word   = mosi & msk;
      end
    end
    if (model_on && release_cs && (ncyc == n)) check("master_rx", got & msk, exp_reply);
    repeat (16) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_miso"}, {31'b0, MISO}, 32'h0);
    check({tag, "_rx_data"}, rx_data, 32'h0);
    check({tag, "_rx_valid"}, {31'b0, rx_valid}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_frame_error"}, {31'b0, frame_error}, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    busy_on_in = 0;
    busy_off_in = 0;
    commit_in = 0;
    m_busy = 1'b0;
    m_valid = 1'b0;
    m_rx = '0;
    m_ferr = 1'b0;
    #1;
    reset_checks(tag);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] got;
    int          p0;
    rst = 1'b1;
    CS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    CPOL = 1'b0;
    CPHA = 1'b0;
    transaction_length = 2'd0;
    tx_data = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0, 8 bits.
    p0 = pulses;
    spi_frame(1'b0, 1'b0, 2'd0, 32'h0000_00A5, 32'h0000_003C, 8, 1'b1, 1'b1, got);
`ifndef SPI_SLAVE_ECHO_EN
    check("m0_master_rx_lit", got, 32'h0000_00A5);
`endif
    check("m0_rx_lit", rx_data, 32'h0000_003C);
    check("m0_pulses", pulses - p0, 32'd1);
    check("m0_ferr_lit", {31'b0, frame_error}, 32'h0);

    // Mode 3, 32 bits.
    spi_frame(1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32, 1'b1, 1'b1, got);
`ifndef SPI_SLAVE_ECHO_EN
    check("m3_master_rx_lit", got, 32'hDEAD_BEEF);
`endif
    check("m3_rx_lit", rx_data, 32'h1234_5678);

    // Modes 1 and 2, 16 bits.
    spi_frame(1'b0, 1'b1, 2'd1, 32'h0000_C3C3, 32'h0000_5A5A, 16, 1'b1, 1'b1, got);
`ifndef SPI_SLAVE_ECHO_EN
    check("m1_master_rx_lit", got, 32'h0000_C3C3);
`endif
    check("m1_rx_lit", rx_data, 32'h0000_5A5A);
    spi_frame(1'b1, 1'b0, 2'd1, 32'h0000_C3C3, 32'h0000_5A5A, 16, 1'b1, 1'b1, got);
`ifndef SPI_SLAVE_ECHO_EN
    check("m2_master_rx_lit", got, 32'h0000_C3C3);
`endif
    check("m2_rx_lit", rx_data, 32'h0000_5A5A);

    // Short 24-bit frame: error, no update; then a good 8-bit frame.
    p0 = pulses;
    spi_frame(1'b0, 1'b0, 2'd2, 32'h00AB_CDEF, 32'h0076_5432, 20, 1'b1, 1'b1, got);
    check("short_ferr_lit", {31'b0, frame_error}, 32'h1);
    check("short_rx_lit", rx_data, 32'h0000_5A5A);
    check("short_pulses", pulses - p0, 32'd0);
    p0 = pulses;
    spi_frame(1'b0, 1'b0, 2'd0, 32'h0000_0081, 32'h0000_00E7, 8, 1'b1, 1'b1, got);
    check("after_err_pulses", pulses - p0, 32'd1);
    check("after_err_rx_lit", rx_data, 32'h0000_00E7);
    check("after_err_ferr_lit", {31'b0, frame_error}, 32'h1);

    // Reset in the middle of a 32-bit frame, then a frame already under way is ignored.
    spi_frame(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'hCAFE_F00D, 10, 1'b0, 1'b1, got);
    check("mid_busy_lit", {31'b0, busy}, 32'h1);
    check("mid_miso_lit", {31'b0, MISO}, 32'h1);
    do_reset("midrst");
    p0 = pulses;
    spi_frame(1'b0, 1'b0, 2'd0, 32'h0000_00FF, 32'h0000_00FF, 4, 1'b1, 1'b0, got);
    check("ghost_pulses", pulses - p0, 32'd0);
    spi_frame(1'b0, 1'b1, 2'd3, 32'h0F1E_2D3C, 32'h89AB_CDEF, 32, 1'b1, 1'b1, got);
`ifndef SPI_SLAVE_ECHO_EN
    check("fresh_master_rx_lit", got, 32'h0F1E_2D3C);
`endif
    check("fresh_rx_lit", rx_data, 32'h89AB_CDEF);
    check("fresh_ferr_lit", {31'b0, frame_error}, 32'h0);

`ifdef SPI_SLAVE_ECHO_EN
    do_reset("echorst");
    spi_frame(1'b0, 1'b0, 2'd0, 32'h0000_0055, 32'h0000_0011, 8, 1'b1, 1'b1, got);
    check("echo0_lit", got, 32'h0000_0000);
    spi_frame(1'b0, 1'b0, 2'd0, 32'h0000_0055, 32'h0000_0022, 8, 1'b1, 1'b1, got);
    check("echo1_lit", got, 32'h0000_0011);
`endif

    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
